// File: rtl/tsi_cond_if.sv
// Board-side signal bundle for the pad conditioning stage. The master modport
// drives raw pad and core levels; the slave modport is the conditioning block.
interface tsi_cond_if #(
  parameter int SW_W  = 8,
  parameter int LED_W = 16
);
  logic [SW_W-1:0]  sw_in;
  logic             rx_in;
  logic             tx_in;
  logic [LED_W-1:0] led_in;
  logic [SW_W-1:0]  sw_out;
  logic [SW_W-1:0]  sw_rise;
  logic [SW_W-1:0]  sw_fall;
  logic             rx_out;
  logic             tx_out;
  logic [LED_W-1:0] led_out;

  modport master (
    output sw_in, rx_in, tx_in, led_in,
    input  sw_out, sw_rise, sw_fall, rx_out, tx_out, led_out
  );

  modport slave (
    input  sw_in, rx_in, tx_in, led_in,
    output sw_out, sw_rise, sw_fall, rx_out, tx_out, led_out
  );
endinterface

// File: rtl/tsi_cond.sv
// Pad conditioning stage: synchronizes and debounces switches (with edge pulses),
// synchronizes RX, and registers TX and LED outputs. Single clock, synchronous reset.
module tsi_cond #(
  parameter int SW_W        = 8,
  parameter int LED_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000,
  parameter int DB_CW       = 10
) (
  input  logic       clk_in,
  input  logic       rst_in,
  tsi_cond_if.slave  bus
);

  localparam logic [DB_CW-1:0] CNT_LAST = DB_CW'(DB_CYCLES - 1);
  localparam logic [DB_CW-1:0] CNT_ONE  = DB_CW'(1);

  logic [SW_W-1:0]        sw_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] rx_sync;
  logic [SW_W-1:0]        sync_sw;
  logic [DB_CW-1:0]       cnt [SW_W];
  logic [SW_W-1:0]        sw_level;
  logic [SW_W-1:0]        rise_q;
  logic [SW_W-1:0]        fall_q;
  logic                   tx_q;
  logic [LED_W-1:0]       led_q;

  // RX idles high, so its chain resets to 1 to avoid a false start bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < SYNC_STAGES; s++) sw_sync[s] <= '0;
      rx_sync <= '1;
    end else begin
      sw_sync[0] <= bus.sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sw_sync[s] <= sw_sync[s-1];
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], bus.rx_in};
    end
  end

  assign sync_sw = sw_sync[SYNC_STAGES-1];

  // A channel changes only after DB_CYCLES consecutive cycles of disagreement;
  // the counter restarts on any agreement, so it never passes CNT_LAST.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sw_level <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < SW_W; i++) cnt[i] <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < SW_W; i++) begin
        if (sync_sw[i] == sw_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_level[i] <= sync_sw[i];
          rise_q[i]   <= sync_sw[i];
          fall_q[i]   <= ~sync_sw[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_q  <= 1'b1;
      led_q <= '0;
    end else begin
      tx_q  <= bus.tx_in;
      led_q <= bus.led_in;
    end
  end

  assign bus.sw_out  = sw_level;
  assign bus.sw_rise = rise_q;
  assign bus.sw_fall = fall_q;
  assign bus.rx_out  = rx_sync[SYNC_STAGES-1];
  assign bus.tx_out  = tx_q;
  assign bus.led_out = led_q;

endmodule

// File: tb/tb_tsi_cond.sv
// Scoreboard bench for tsi_cond (SYNC_STAGES=2, DB_CYCLES=4): expected pulse
// events and level snapshots are queued up front and consumed by a monitor.
module tb_tsi_cond;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] sw;
  } pulse_exp_t;

  typedef struct {
    int          cyc;
    logic [7:0]  sw;
    logic        rx;
    logic        tx;
    logic [15:0] led;
  } level_exp_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  pulse_exp_t pulse_q[$];
  level_exp_t level_q[$];
  pulse_exp_t pe;
  level_exp_t le;

  tsi_cond_if #(.SW_W(8), .LED_W(16)) bus ();

  tsi_cond #(
    .SW_W(8), .LED_W(16), .SYNC_STAGES(2), .DB_CYCLES(4), .DB_CW(3)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void expect_pulse(int c, logic [7:0] r, logic [7:0] f, logic [7:0] s);
    pulse_exp_t p;
    p.cyc = c; p.rise = r; p.fall = f; p.sw = s;
    pulse_q.push_back(p);
  endfunction

  function automatic void expect_level(int c, logic [7:0] s, logic r, logic t, logic [15:0] l);
    level_exp_t v;
    v.cyc = c; v.sw = s; v.rx = r; v.tx = t; v.led = l;
    level_q.push_back(v);
  endfunction

  // Inputs change on the falling edge after cycle 'at', so the first rising edge to see them is at+1.
  task automatic apply_stimulus(input int at, input logic rst, input logic [7:0] sw,
                                input logic rx, input logic tx, input logic [15:0] led);
    while (cyc < at) @(negedge clk_in);
    rst_in     = rst;
    bus.sw_in  = sw;
    bus.rx_in  = rx;
    bus.tx_in  = tx;
    bus.led_in = led;
  endtask

  always @(negedge clk_in) begin
    if (!done) begin
      if ((|bus.sw_rise) || (|bus.sw_fall)) begin
        if (pulse_q.size() == 0) begin
          check_output("unexpected_pulse", {8'h0, bus.sw_rise, 8'h0, bus.sw_fall}, 32'h0);
        end else begin
          pe = pulse_q.pop_front();
          check_output("pulse_cycle", cyc, pe.cyc);
          check_output("sw_rise", {24'h0, bus.sw_rise}, {24'h0, pe.rise});
          check_output("sw_fall", {24'h0, bus.sw_fall}, {24'h0, pe.fall});
          check_output("sw_out_at_pulse", {24'h0, bus.sw_out}, {24'h0, pe.sw});
        end
      end
      while (level_q.size() > 0 && level_q[0].cyc <= cyc) begin
        le = level_q.pop_front();
        check_output("level_cycle", cyc, le.cyc);
        check_output("sw_out", {24'h0, bus.sw_out}, {24'h0, le.sw});
        check_output("rx_out", {31'h0, bus.rx_out}, {31'h0, le.rx});
        check_output("tx_out", {31'h0, bus.tx_out}, {31'h0, le.tx});
        check_output("led_out", {16'h0, bus.led_out}, {16'h0, le.led});
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with every input high, then release: all switches qualify 6 cycles later.
    expect_level(1, 8'h00, 1'b1, 1'b1, 16'h0000);
    expect_level(2, 8'h00, 1'b1, 1'b1, 16'h0000);
    expect_level(3, 8'h00, 1'b1, 1'b1, 16'h0000);
    expect_level(4, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    expect_pulse(9, 8'hFF, 8'h00, 8'hFF);
    expect_pulse(18, 8'h00, 8'hFF, 8'h00);
    expect_pulse(26, 8'h08, 8'h00, 8'h08);
    expect_pulse(34, 8'h00, 8'h08, 8'h00);
    expect_level(47, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    expect_level(51, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    expect_pulse(52, 8'h01, 8'h00, 8'h01);
    expect_pulse(56, 8'h00, 8'h01, 8'h00);
    expect_pulse(66, 8'hA5, 8'h00, 8'hA5);
    expect_pulse(76, 8'h00, 8'hA5, 8'h00);
    expect_level(81, 8'h00, 1'b1, 1'b0, 16'h1234);
    expect_level(82, 8'h00, 1'b0, 1'b0, 16'h1234);
    expect_level(85, 8'h00, 1'b0, 1'b1, 16'h0000);
    expect_level(86, 8'h00, 1'b1, 1'b1, 16'h0000);
    expect_level(89, 8'h00, 1'b1, 1'b1, 16'h5A5A);
    expect_level(95, 8'h00, 1'b1, 1'b1, 16'h0000);
    expect_level(100, 8'h00, 1'b1, 1'b1, 16'h5A5A);
    expect_pulse(101, 8'h20, 8'h00, 8'h20);

    apply_stimulus(0,  1'b1, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(3,  1'b0, 8'hFF, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(12, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(20, 1'b0, 8'h08, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(28, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    // Bounce: two 3-cycle highs are rejected, the 4-cycle high is accepted.
    apply_stimulus(36, 1'b0, 8'h01, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(39, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(40, 1'b0, 8'h01, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(43, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(46, 1'b0, 8'h01, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(50, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(60, 1'b0, 8'hA5, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(70, 1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    apply_stimulus(80, 1'b0, 8'h00, 1'b0, 1'b0, 16'h1234);
    apply_stimulus(84, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0000);
    apply_stimulus(88, 1'b0, 8'h00, 1'b1, 1'b1, 16'h5A5A);
    // Reset lands while channel 5 is mid-count; it must re-qualify from zero.
    apply_stimulus(90, 1'b0, 8'h20, 1'b1, 1'b1, 16'h5A5A);
    apply_stimulus(94, 1'b1, 8'h20, 1'b1, 1'b1, 16'h5A5A);
    apply_stimulus(95, 1'b0, 8'h20, 1'b1, 1'b1, 16'h5A5A);

    while (cyc < 110) @(negedge clk_in);
    #1;
    done = 1'b1;
    while (pulse_q.size() > 0) begin
      pe = pulse_q.pop_front();
      check_output("pulse_missing", 32'(cyc), 32'(pe.cyc));
    end
    while (level_q.size() > 0) begin
      le = level_q.pop_front();
      check_output("level_missing", 32'(cyc), 32'(le.cyc));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
